// File: rtl/tiktak_scoreboard.sv
// Match scoreboard for the tik-tak game FSM: it counts wins, draws and fouls, and restarts rounds through game_rst_n.
// Optional build macro TIKTAK_FOUL_PENALTY_EN: a single foul also awards a point to the opponent.
module tiktak_scoreboard #(
    parameter int WIN_TARGET     = 3,
    parameter int RESTART_CYCLES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       match_start,
    input  logic       p1,
    input  logic       p2,
    input  logic       ilg1,
    input  logic       ilg2,
    input  logic       nospace,
    output logic       game_rst_n,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [3:0] draws,
    output logic [3:0] fouls1,
    output logic [3:0] fouls2,
    output logic       round_done,
    output logic       match_done,
    output logic [1:0] winner
);

    // state   | meaning
    // IDLE    | after reset, waiting for match_start, game held in reset
    // RESTART | game held in reset for RESTART_CYCLES cycles between rounds
    // PLAY    | game running, first status event ends the round
    // DONE    | a player reached WIN_TARGET, waiting for match_start
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RESTART = 2'd1;
    localparam logic [1:0] S_PLAY    = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [3:0] WIN_T    = 4'(WIN_TARGET);
    localparam logic [3:0] RST_LOAD = 4'(RESTART_CYCLES - 1);

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    logic [1:0] state, state_nxt;
    logic [3:0] rst_cnt, rst_cnt_nxt;
    logic [3:0] score1_nxt, score2_nxt, draws_nxt, fouls1_nxt, fouls2_nxt;
    logic [1:0] winner_nxt;
    logic       round_done_nxt;
    logic       resolved;

    // Bit order: {nospace, ilg2, ilg1, p2, p1}. stat_q is the single capture
    // stage; stat_d is its previous value, used only for rise detection.
    logic [4:0] stat_q, stat_d, ev;
    logic       ev_p1, ev_p2, ev_i1, ev_i2, ev_ns;

    assign ev    = stat_q & ~stat_d;
    assign ev_p1 = ev[0];
    assign ev_p2 = ev[1];
    assign ev_i1 = ev[2];
    assign ev_i2 = ev[3];
    assign ev_ns = ev[4];

    assign game_rst_n = (state == S_PLAY);
    assign match_done = (state == S_DONE);

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_q <= '0;
            stat_d <= '0;
        end else begin
            stat_q <= {nospace, ilg2, ilg1, p2, p1};
            stat_d <= stat_q;
        end
    end

    always_comb begin
        state_nxt      = state;
        rst_cnt_nxt    = rst_cnt;
        score1_nxt     = score1;
        score2_nxt     = score2;
        draws_nxt      = draws;
        fouls1_nxt     = fouls1;
        fouls2_nxt     = fouls2;
        winner_nxt     = winner;
        round_done_nxt = 1'b0;
        resolved       = 1'b0;

        if (match_start) begin
            state_nxt   = S_RESTART;
            rst_cnt_nxt = RST_LOAD;
            score1_nxt  = '0;
            score2_nxt  = '0;
            draws_nxt   = '0;
            fouls1_nxt  = '0;
            fouls2_nxt  = '0;
            winner_nxt  = WIN_NONE;
        end else begin
            case (state)
                S_RESTART: begin
                    if (rst_cnt == 4'd0) begin
                        state_nxt = S_PLAY;
                    end else begin
                        rst_cnt_nxt = rst_cnt - 4'd1;
                    end
                end
                S_PLAY: begin
                    if (ev_p1 && ev_p2) begin
                        draws_nxt = sat_inc(draws);
                        resolved  = 1'b1;
                    end else if (ev_p1) begin
                        score1_nxt = sat_inc(score1);
                        resolved   = 1'b1;
                    end else if (ev_p2) begin
                        score2_nxt = sat_inc(score2);
                        resolved   = 1'b1;
                    end else if (ev_ns) begin
                        draws_nxt = sat_inc(draws);
                        resolved  = 1'b1;
                    end else if (ev_i1 && ev_i2) begin
                        fouls1_nxt = sat_inc(fouls1);
                        fouls2_nxt = sat_inc(fouls2);
                        resolved   = 1'b1;
                    end else if (ev_i1) begin
                        fouls1_nxt = sat_inc(fouls1);
`ifdef TIKTAK_FOUL_PENALTY_EN
                        score2_nxt = sat_inc(score2);
`endif
                        resolved   = 1'b1;
                    end else if (ev_i2) begin
                        fouls2_nxt = sat_inc(fouls2);
`ifdef TIKTAK_FOUL_PENALTY_EN
                        score1_nxt = sat_inc(score1);
`endif
                        resolved   = 1'b1;
                    end

                    if (resolved) begin
                        round_done_nxt = 1'b1;
                        if (score1_nxt >= WIN_T) begin
                            state_nxt  = S_DONE;
                            winner_nxt = WIN_P1;
                        end else if (score2_nxt >= WIN_T) begin
                            state_nxt  = S_DONE;
                            winner_nxt = WIN_P2;
                        end else begin
                            state_nxt   = S_RESTART;
                            rst_cnt_nxt = RST_LOAD;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE only leave on match_start.
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            rst_cnt    <= '0;
            score1     <= '0;
            score2     <= '0;
            draws      <= '0;
            fouls1     <= '0;
            fouls2     <= '0;
            winner     <= WIN_NONE;
            round_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            rst_cnt    <= rst_cnt_nxt;
            score1     <= score1_nxt;
            score2     <= score2_nxt;
            draws      <= draws_nxt;
            fouls1     <= fouls1_nxt;
            fouls2     <= fouls2_nxt;
            winner     <= winner_nxt;
            round_done <= round_done_nxt;
        end
    end

endmodule

// File: tb/tb_tiktak_scoreboard.sv
// Directed bench for tiktak_scoreboard: vector table of single rounds plus hand-written match sequences.
module tb_tiktak_scoreboard;

`ifdef TIKTAK_FOUL_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       match_start;
    logic       p1, p2, ilg1, ilg2, nospace;
    logic       game_rst_n;
    logic [3:0] score1, score2, draws, fouls1, fouls2;
    logic       round_done, match_done;
    logic [1:0] winner;

    int errors = 0;
    int checks = 0;

    tiktak_scoreboard #(.WIN_TARGET(3), .RESTART_CYCLES(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .match_start(match_start),
        .p1         (p1),
        .p2         (p2),
        .ilg1       (ilg1),
        .ilg2       (ilg2),
        .nospace    (nospace),
        .game_rst_n (game_rst_n),
        .score1     (score1),
        .score2     (score2),
        .draws      (draws),
        .fouls1     (fouls1),
        .fouls2     (fouls2),
        .round_done (round_done),
        .match_done (match_done),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    // stim bit order: {nospace, ilg2, ilg1, p2, p1}
    typedef struct {
        logic [4:0] stim;
        int         s1, s2, d, f1, f2;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] s);
        p1      = s[0];
        p2      = s[1];
        ilg1    = s[2];
        ilg2    = s[3];
        nospace = s[4];
    endtask

    task automatic start_match();
        @(negedge clk);
        match_start = 1'b1;
        @(negedge clk);
        match_start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // One-cycle input pulse, then six cycles: enough to finish RESTART and be back in PLAY.
    task automatic apply_round(input logic [4:0] s, output int rd_cnt);
        rd_cnt = 0;
        @(negedge clk);
        drive(s);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) drive(5'b0);
            rd_cnt += int'(round_done);
        end
    endtask

    task automatic check_all(input string tag, input int s1, input int s2, input int d,
                             input int f1, input int f2);
        chk({tag, " score1"}, int'(score1), s1);
        chk({tag, " score2"}, int'(score2), s2);
        chk({tag, " draws"},  int'(draws),  d);
        chk({tag, " fouls1"}, int'(fouls1), f1);
        chk({tag, " fouls2"}, int'(fouls2), f2);
    endtask

    initial begin
        int rd, lo, rd_idx;

        tbl[0] = '{5'b00001, 1,       0,       0, 0, 0};
        tbl[1] = '{5'b00010, 1,       1,       0, 0, 0};
        tbl[2] = '{5'b00011, 1,       1,       1, 0, 0};
        tbl[3] = '{5'b10000, 1,       1,       2, 0, 0};
        tbl[4] = '{5'b01100, 1,       1,       2, 1, 1};
        tbl[5] = '{5'b00100, 1,       1 + PEN, 2, 2, 1};
        tbl[6] = '{5'b01000, 1 + PEN, 1 + PEN, 2, 2, 2};
        tbl[7] = '{5'b10100, 1 + PEN, 1 + PEN, 3, 2, 2};

        resetn = 1'b0;
        match_start = 1'b0;
        drive(5'b0);
        repeat (3) @(negedge clk);
        check_all("reset", 0, 0, 0, 0, 0);
        chk("reset game_rst_n", int'(game_rst_n), 0);
        chk("reset match_done", int'(match_done), 0);
        chk("reset winner", int'(winner), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle game_rst_n", int'(game_rst_n), 0);

        // p1 held for five cycles counts once; round_done two edges after drive
        start_match();
        chk("play game_rst_n", int'(game_rst_n), 1);
        rd = 0; lo = 0; rd_idx = -1;
        p1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 5) p1 = 1'b0;
            if (round_done) begin
                rd++;
                rd_idx = i;
            end
            if (!game_rst_n) lo++;
        end
        chk("held p1 round_done count", rd, 1);
        chk("held p1 round_done latency", rd_idx, 2);
        chk("held p1 restart low cycles", lo, 2);
        chk("held p1 score1", int'(score1), 1);
        chk("held p1 back to play", int'(game_rst_n), 1);

        // table of single rounds, cumulative within one match
        start_match();
        check_all("match_start clear", 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            apply_round(tbl[i].stim, rd);
            chk($sformatf("vec%0d round_done", i), rd, 1);
            check_all($sformatf("vec%0d", i), tbl[i].s1, tbl[i].s2, tbl[i].d, tbl[i].f1, tbl[i].f2);
            chk($sformatf("vec%0d match_done", i), int'(match_done), 0);
        end

        // three p2 wins end the match
        start_match();
        for (int i = 0; i < 3; i++) apply_round(5'b00010, rd);
        chk("p2 match score2", int'(score2), 3);
        chk("p2 match match_done", int'(match_done), 1);
        chk("p2 match winner", int'(winner), 2);
        chk("done game_rst_n", int'(game_rst_n), 0);
        apply_round(5'b00001, rd);
        chk("done ignores p1 round_done", rd, 0);
        chk("done ignores p1 score1", int'(score1), 0);
        chk("done holds winner", int'(winner), 2);
        @(negedge clk);
        match_start = 1'b1;
        @(negedge clk);
        match_start = 1'b0;
        chk("rematch match_done", int'(match_done), 0);
        chk("rematch winner", int'(winner), 0);
        check_all("rematch", 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        // draws saturate at 15
        start_match();
        for (int i = 0; i < 16; i++) apply_round(5'b10000, rd);
        chk("draws saturate", int'(draws), 15);
        chk("draws saturate round_done", rd, 1);

        // asynchronous reset mid-RESTART
        start_match();
        @(negedge clk);
        p1 = 1'b1;
        @(negedge clk);
        p1 = 1'b0;
        @(negedge clk);
        chk("pre-reset round_done", int'(round_done), 1);
        chk("pre-reset score1", int'(score1), 1);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async reset score1", int'(score1), 0);
        chk("async reset round_done", int'(round_done), 0);
        chk("async reset game_rst_n", int'(game_rst_n), 0);
        chk("async reset winner", int'(winner), 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("after reset stays idle", int'(game_rst_n), 0);

        // match_start on the same edge as a p1 event discards the event
        start_match();
        apply_round(5'b00001, rd);
        chk("pre-restart score1", int'(score1), 1);
        @(negedge clk);
        p1 = 1'b1;
        @(negedge clk);
        match_start = 1'b1;
        rd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                match_start = 1'b0;
                p1 = 1'b0;
            end
            rd += int'(round_done);
        end
        chk("start+p1 round_done", rd, 0);
        check_all("start+p1", 0, 0, 0, 0, 0);
        chk("start+p1 back to play", int'(game_rst_n), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
